// File: rtl/step_counter_7seg.sv
// step_counter_7seg
//   Modulo-MODULUS up/down counter advanced by an internal prescaler tick,
//   with a configurable step, wrap or saturate at the bounds, a synchronous
//   load, and an IDLE/RUN/PAUSED control FSM. The count is shown on DIGITS
//   active-low hex seven-segment digits.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-low reset
//   start     level, requests RUN
//   stop      level, requests PAUSED (from RUN) or IDLE (from PAUSED)
//   dir       0 = count up, 1 = count down (sampled on tick cycles only)
//   step      increment per tick, reduced mod MODULUS (sampled on ticks only)
//   sat_mode  0 = wrap, 1 = saturate (sampled on tick cycles only)
//   load      synchronous load strobe, wins over tick and stop-clear
//   load_val  value to load, clamped to MODULUS-1
//   count     current count
//   seg       digit i on seg[7i+6:7i], segments a..g MSB first, active-low
//   carry     one-clk pulse after a wrap or clamp
//   state     00 IDLE, 01 RUN, 10 PAUSED
module step_counter_7seg #(
    parameter int DIV_COUNT = 25000000,
    parameter int DIGITS    = 2,
    parameter int MODULUS   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  dir,
    input  logic [3:0]            step,
    input  logic                  sat_mode,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  carry,
    output logic [1:0]            state
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = $clog2(DIV_COUNT);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_COUNT - 1);
    // Arithmetic is done one bit wider than the count so count+s never overflows.
    localparam logic [CW:0]   MOD_V      = (CW+1)'(MODULUS);
    localparam logic [CW:0]   MOD_MAX    = MOD_V - (CW+1)'(1);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_PAUSED = 2'b10;

    logic [1:0]    state_r;
    logic [1:0]    next_state_s;
    logic          clear_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_next_s;
    logic          tick_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          carry_r;
    logic          carry_next_s;
    logic [CW:0]   count_ext_s;
    logic [CW:0]   s_s;
    logic [CW:0]   sum_s;
    logic [CW-1:0] upd_s;
    logic          upd_carry_s;
    logic [CW-1:0] load_fix_s;

    // Active-low hex seven-segment decode, segments a..g MSB first.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b0000001;
            4'h1:    pat = 7'b1001111;
            4'h2:    pat = 7'b0010010;
            4'h3:    pat = 7'b0000110;
            4'h4:    pat = 7'b1001100;
            4'h5:    pat = 7'b0100100;
            4'h6:    pat = 7'b0100000;
            4'h7:    pat = 7'b0001111;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0000100;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b1100000;
            4'hC:    pat = 7'b0110001;
            4'hD:    pat = 7'b1000010;
            4'hE:    pat = 7'b0110000;
            4'hF:    pat = 7'b0111000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // Control FSM next state; start and stop together never cause a transition.
    always_comb begin
        next_state_s = state_r;
        clear_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop && !start) begin
                    next_state_s = ST_PAUSED;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (start && !stop) begin
                    next_state_s = ST_RUN;
                end else if (stop && !start) begin
                    next_state_s = ST_IDLE;
                    clear_s      = 1'b1;
                end else begin
                    next_state_s = ST_PAUSED;
                end
            end
            default: begin
                // Unreachable encoding: fall back to IDLE and clear.
                next_state_s = ST_IDLE;
                clear_s      = 1'b1;
            end
        endcase
    end

    // Prescaler: counts only in RUN, holds in PAUSED, cleared on the way to IDLE.
    always_comb begin
        tick_s = (state_r == ST_RUN) && (presc_r == PRESC_LAST);
        if (clear_s) begin
            presc_next_s = {PW{1'b0}};
        end else if (state_r == ST_RUN) begin
            if (tick_s) begin
                presc_next_s = {PW{1'b0}};
            end else begin
                presc_next_s = presc_r + PW'(1);
            end
        end else begin
            presc_next_s = presc_r;
        end
    end

    // Tick arithmetic: wrap or clamp result plus the carry flag.
    always_comb begin
        count_ext_s = {1'b0, count_r};
        s_s         = (CW+1)'(step) % MOD_V;
        sum_s       = count_ext_s + s_s;
        if (!dir) begin
            if (sum_s > MOD_MAX) begin
                upd_carry_s = 1'b1;
                if (sat_mode) begin
                    upd_s = MOD_MAX[CW-1:0];
                end else begin
                    upd_s = CW'(sum_s - MOD_V);
                end
            end else begin
                upd_carry_s = 1'b0;
                upd_s       = CW'(sum_s);
            end
        end else begin
            if (s_s > count_ext_s) begin
                upd_carry_s = 1'b1;
                if (sat_mode) begin
                    upd_s = {CW{1'b0}};
                end else begin
                    upd_s = CW'(count_ext_s + MOD_V - s_s);
                end
            end else begin
                upd_carry_s = 1'b0;
                upd_s       = CW'(count_ext_s - s_s);
            end
        end
    end

    // Next count: load beats stop-clear, which beats a tick; a tick lost to load gives no carry.
    always_comb begin
        if ({1'b0, load_val} > MOD_MAX) begin
            load_fix_s = MOD_MAX[CW-1:0];
        end else begin
            load_fix_s = load_val;
        end
        if (load) begin
            count_next_s = load_fix_s;
            carry_next_s = 1'b0;
        end else if (clear_s) begin
            count_next_s = {CW{1'b0}};
            carry_next_s = 1'b0;
        end else if (tick_s) begin
            count_next_s = upd_s;
            carry_next_s = upd_carry_s;
        end else begin
            count_next_s = count_r;
            carry_next_s = 1'b0;
        end
    end

    // State, prescaler, count and carry registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            presc_r <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            carry_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            presc_r <= presc_next_s;
            count_r <= count_next_s;
            carry_r <= carry_next_s;
        end
    end

    // One decoder per nibble, digit 0 on the least significant nibble.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_digit
            assign seg[7*gi +: 7] = hex_to_seg(count_r[4*gi +: 4]);
        end
    endgenerate

    assign count = count_r;
    assign carry = carry_r;
    assign state = state_r;

endmodule

// File: tb/tb_step_counter_7seg.sv
module tb_step_counter_7seg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: DIV_COUNT=4, MODULUS=6
    logic        reset_a, start_a, stop_a, dir_a, sat_a, load_a;
    logic [3:0]  step_a;
    logic [7:0]  load_val_a, count_a;
    logic [13:0] seg_a;
    logic        carry_a;
    logic [1:0]  state_a;

    // DUT B: DIV_COUNT=4, MODULUS=200
    logic        reset_b, start_b, stop_b, dir_b, sat_b, load_b;
    logic [3:0]  step_b;
    logic [7:0]  load_val_b, count_b;
    logic [13:0] seg_b;
    logic        carry_b;
    logic [1:0]  state_b;

    step_counter_7seg #(.DIV_COUNT(4), .DIGITS(2), .MODULUS(6)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .stop(stop_a), .dir(dir_a),
        .step(step_a), .sat_mode(sat_a), .load(load_a), .load_val(load_val_a),
        .count(count_a), .seg(seg_a), .carry(carry_a), .state(state_a));

    step_counter_7seg #(.DIV_COUNT(4), .DIGITS(2), .MODULUS(200)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .stop(stop_b), .dir(dir_b),
        .step(step_b), .sat_mode(sat_b), .load(load_b), .load_val(load_val_b),
        .count(count_b), .seg(seg_b), .carry(carry_b), .state(state_b));

    typedef struct {
        string nm;
        int    cnt;
        bit    cy;
        int    at;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   prev_cnt = 0;
    int   c0, tk;

    always @(posedge clk) cyc++;

    function automatic logic [6:0] seg_model(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input string nm, input int cnt, input bit cy, input int at);
        exp_t e;
        e.nm = nm; e.cnt = cnt; e.cy = cy; e.at = at;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every count change or carry pulse on DUT A is an output event.
    always @(negedge clk) begin
        if (mon_en) begin
            if ((int'(count_a) != prev_cnt) || carry_a) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got count=%0d carry=%0d at cycle %0d, expected no update",
                             count_a, carry_a, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk({mon_e.nm, "_count"}, int'(count_a), mon_e.cnt);
                    chk({mon_e.nm, "_carry"}, int'(carry_a), int'(mon_e.cy));
                    chk({mon_e.nm, "_cycle"}, cyc, mon_e.at);
                    chk({mon_e.nm, "_seg0"}, int'(seg_a[6:0]), int'(seg_model(mon_e.cnt[3:0])));
                    chk({mon_e.nm, "_seg1"}, int'(seg_a[13:7]), int'(7'b0000001));
                end
            end
            prev_cnt = int'(count_a);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_a = 1'b0; start_a = 1'b0; stop_a = 1'b0; dir_a = 1'b0; sat_a = 1'b0;
        load_a = 1'b0; step_a = 4'd0; load_val_a = 8'd0;
        reset_b = 1'b0; start_b = 1'b0; stop_b = 1'b0; dir_b = 1'b0; sat_b = 1'b0;
        load_b = 1'b0; step_b = 4'd0; load_val_b = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_count", int'(count_a), 0);
        chk("reset_state", int'(state_a), 0);
        chk("reset_carry", int'(carry_a), 0);
        chk("reset_seg", int'(seg_a), int'(14'b00000010000001));
        reset_a = 1'b1;
        reset_b = 1'b1;
        @(negedge clk);
        prev_cnt = 0;
        mon_en = 1'b1;

        // Up, step 1, wrap: 1,2,3,4,5,0 every 4 clks, carry on 5->0.
        c0 = cyc;
        start_a = 1'b1; dir_a = 1'b0; step_a = 4'd1; sat_a = 1'b0;
        tk = c0 + 5;
        for (int k = 0; k < 6; k++) push("up_wrap", (k + 1) % 6, (k == 5), tk + 4 * k);
        wait_cyc(c0 + 1);
        start_a = 1'b0;
        chk("run_state", int'(state_a), 1);
        wait_cyc(tk + 16);
        chk("seg_at5", int'(seg_a[6:0]), int'(7'b0100100));
        wait_cyc(tk + 20);
        tk = tk + 24;

        // Down wrap, step 4 from 1 -> 3 -> 5 (carry), then step 9 acts as 3.
        load_a = 1'b1; load_val_a = 8'd1; dir_a = 1'b1; step_a = 4'd4;
        push("load1", 1, 1'b0, tk - 3);
        wait_cyc(tk - 3);
        load_a = 1'b0;
        push("down4_a", 3, 1'b1, tk);
        push("down4_b", 5, 1'b1, tk + 4);
        wait_cyc(tk + 4);
        step_a = 4'd9;
        push("step9", 2, 1'b0, tk + 8);
        wait_cyc(tk + 8);
        tk = tk + 12;

        // Saturate: up 4 from 3 -> 5 twice with carry; down 3 from 2 -> 0.
        sat_a = 1'b1; dir_a = 1'b0; step_a = 4'd4;
        load_a = 1'b1; load_val_a = 8'd3;
        push("load3", 3, 1'b0, tk - 3);
        wait_cyc(tk - 3);
        load_a = 1'b0;
        push("sat_up_a", 5, 1'b1, tk);
        push("sat_up_b", 5, 1'b1, tk + 4);
        wait_cyc(tk + 4);
        load_a = 1'b1; load_val_a = 8'd2; dir_a = 1'b1; step_a = 4'd3;
        push("load2", 2, 1'b0, tk + 5);
        wait_cyc(tk + 5);
        load_a = 1'b0;
        push("sat_dn", 0, 1'b1, tk + 8);
        wait_cyc(tk + 8);
        sat_a = 1'b0; dir_a = 1'b0; step_a = 4'd0;
        wait_cyc(tk + 12);
        chk("step0_count", int'(count_a), 0);
        chk("step0_carry", int'(carry_a), 0);
        step_a = 4'd1;
        tk = tk + 16;

        // Pause with prescaler at 2, hold, resume: update 2 clks after resume.
        push("pre_pause", 1, 1'b0, tk);
        wait_cyc(tk + 1);
        stop_a = 1'b1;
        wait_cyc(tk + 2);
        stop_a = 1'b0;
        chk("paused_state", int'(state_a), 2);
        wait_cyc(tk + 12);
        chk("frozen_count", int'(count_a), 1);
        start_a = 1'b1;
        push("resume", 2, 1'b0, tk + 15);
        wait_cyc(tk + 13);
        start_a = 1'b0;
        chk("resumed_state", int'(state_a), 1);
        wait_cyc(tk + 15);
        stop_a = 1'b1;
        push("stop_clear", 0, 1'b0, tk + 17);
        wait_cyc(tk + 17);
        stop_a = 1'b0;
        chk("idle_state", int'(state_a), 0);

        // Load clamp, load beating a tick, load beating the stop-clear.
        c0 = cyc;
        load_a = 1'b1; load_val_a = 8'd9;
        push("load_clamp", 5, 1'b0, c0 + 1);
        wait_cyc(c0 + 1);
        load_a = 1'b0; start_a = 1'b1;
        wait_cyc(c0 + 2);
        start_a = 1'b0;
        wait_cyc(c0 + 5);
        load_a = 1'b1; load_val_a = 8'd2;
        push("load_tick", 2, 1'b0, c0 + 6);
        wait_cyc(c0 + 6);
        load_a = 1'b0;
        push("after_load_tick", 3, 1'b0, c0 + 10);
        wait_cyc(c0 + 10);
        stop_a = 1'b1;
        wait_cyc(c0 + 11);
        chk("pause_before_clear", int'(state_a), 2);
        load_a = 1'b1; load_val_a = 8'd4;
        push("load_vs_clear", 4, 1'b0, c0 + 12);
        wait_cyc(c0 + 12);
        load_a = 1'b0; stop_a = 1'b0;
        chk("idle_after_clear", int'(state_a), 0);

        // start and stop together: no transition.
        start_a = 1'b1; stop_a = 1'b1;
        wait_cyc(c0 + 14);
        chk("both_idle", int'(state_a), 0);
        start_a = 1'b0; stop_a = 1'b0;
        wait_cyc(c0 + 16);
        chk("sb_drained", sb_q.size(), 0);

        // DUT B: two-digit display of 0xC7, then async reset mid-run.
        load_b = 1'b1; load_val_b = 8'hC7;
        @(negedge clk);
        load_b = 1'b0;
        chk("b_load_count", int'(count_b), 199);
        chk("b_seg_digit1", int'(seg_b[13:7]), int'(7'b0110001));
        chk("b_seg_digit0", int'(seg_b[6:0]), int'(7'b0001111));
        c0 = cyc;
        step_b = 4'd2; dir_b = 1'b0; sat_b = 1'b0; start_b = 1'b1;
        wait_cyc(c0 + 1);
        start_b = 1'b0;
        wait_cyc(c0 + 5);
        chk("b_wrap_count", int'(count_b), 1);
        chk("b_wrap_carry", int'(carry_b), 1);
        chk("b_run_state", int'(state_b), 1);
        #2 reset_b = 1'b0;
        #1;
        chk("b_async_count", int'(count_b), 0);
        chk("b_async_state", int'(state_b), 0);
        chk("b_async_carry", int'(carry_b), 0);
        chk("b_async_seg", int'(seg_b), int'(14'b00000010000001));

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
